pl_fetch: RTL and testbench

//  Instruction-fetch stage. Owns the PC, issues instruction-memory reads,
//  and produces instruction/next_address plus write-enable and flush for the
//  IF/ID pipeline register. Redirects (branch/jump) come from later stages.

---
 rtl/pl_fetch.sv | 105 ++++++++++
 tb/tb_pl_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pl_fetch.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory reads and
// the IF/ID write-enable/flush, deferring redirects that arrive during a miss.
module pl_fetch #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic [31:0] instruction_out,
  output logic [31:0] next_address_out
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_addr, pend_n;
  logic [31:0] redir_aligned;
  logic [31:0] pc_plus4;

  assign redir_aligned    = redirect_addr & ~32'h3;
  assign pc_plus4         = pc + 32'd4;
  assign imemaddr         = pc;
  assign instruction_out  = imemload;
  assign next_address_out = pc_plus4;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      pc        <= PC_INIT;
      pend_addr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pend_addr <= pend_n;
    end
  end

  // PC only moves on a cycle with ihit, so the read address is stable across misses.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend_addr;
    imemREN    = 1'b0;
    ifid_wen   = 1'b0;
    ifid_flush = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          imemREN = 1'b1;
          if (halt) begin
            state_n = HALTED;
          end else if (redirect_valid) begin
            ifid_flush = 1'b1;
            if (ihit) begin
              pc_n = redir_aligned;
            end else begin
              pend_n  = redir_aligned;
              state_n = PEND;
            end
          end else if (ihit && !stall) begin
            ifid_wen = 1'b1;
            pc_n     = pc_plus4;
          end
        end
        PEND: begin
          imemREN = 1'b1;
          if (halt) begin
            state_n = HALTED;
          end else begin
            if (redirect_valid) begin
              ifid_flush = 1'b1;
              pend_n     = redir_aligned;
            end
            // A redirect arriving on the completing cycle wins over the stored one.
            if (ihit) begin
              pc_n    = redirect_valid ? redir_aligned : pend_addr;
              state_n = RUN;
            end
          end
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pl_fetch.sv
// Scoreboard bench for pl_fetch: a behavioural model predicts each cycle's
// outputs, a monitor pops and compares them at the falling edge.
module tb_pl_fetch;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        ifid_wen;
  logic        ifid_flush;
  logic [31:0] instruction_out;
  logic [31:0] next_address_out;

  pl_fetch #(.PC_INIT(PC_INIT)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .imemREN          (imemREN),
    .imemaddr         (imemaddr),
    .ihit             (ihit),
    .imemload         (imemload),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .halt             (halt),
    .ifid_wen         (ifid_wen),
    .ifid_flush       (ifid_flush),
    .instruction_out  (instruction_out),
    .next_address_out (next_address_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wen;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] nxt;
    logic        hit;
    logic        rst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_has_pend;
  logic        m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic rv, input logic [31:0] ra,
                      input logic hit, input logic st, input logic [31:0] ld);
    exp_t e;
    @(posedge CLK);
    #2;
    RST = r; halt = h; redirect_valid = rv; redirect_addr = ra;
    ihit = hit; stall = st; imemload = ld;
    e.ren   = !r && !m_halted;
    e.addr  = m_pc;
    e.instr = ld;
    e.nxt   = m_pc + 32'd4;
    e.wen   = 1'b0;
    e.flush = 1'b0;
    e.hit   = hit;
    e.rst   = r;
    if (r) begin
      m_pc = PC_INIT; m_has_pend = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (h) begin
      m_halted = 1'b1; m_has_pend = 1'b0;
    end else if (m_has_pend) begin
      if (rv) begin
        e.flush = 1'b1; m_pend = {ra[31:2], 2'b00};
      end
      if (hit) begin
        m_pc = m_pend; m_has_pend = 1'b0;
      end
    end else if (rv) begin
      e.flush = 1'b1;
      if (hit) m_pc = {ra[31:2], 2'b00};
      else begin
        m_pend = {ra[31:2], 2'b00}; m_has_pend = 1'b1;
      end
    end else if (hit && !st) begin
      e.wen = 1'b1;
      m_pc  = m_pc + 32'd4;
    end
    sb.push_back(e);
  endtask

  // Monitor: compares every presented cycle, plus the miss-hold handshake rule.
  initial begin
    exp_t        e;
    logic        prev_valid = 1'b0;
    logic        prev_hit   = 1'b0;
    logic        prev_rst   = 1'b0;
    logic [31:0] prev_addr  = '0;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imemREN", {31'd0, imemREN}, {31'd0, e.ren});
        chk("imemaddr", imemaddr, e.addr);
        chk("ifid_wen", {31'd0, ifid_wen}, {31'd0, e.wen});
        chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.flush});
        chk("instruction_out", instruction_out, e.instr);
        chk("next_address_out", next_address_out, e.nxt);
        if (prev_valid && !prev_rst && !prev_hit)
          chk("addr_hold_on_miss", imemaddr, prev_addr);
        prev_valid = 1'b1;
        prev_hit   = e.hit;
        prev_rst   = e.rst;
        prev_addr  = imemaddr;
      end
    end
  end

  initial begin
    RST = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    ihit = 1'b0; stall = 1'b0; imemload = '0;
    repeat (2) @(posedge CLK);
    m_pc = PC_INIT; m_pend = '0; m_has_pend = 1'b0; m_halted = 1'b0;

    // Straight-line fetch from reset
    step(0,0,0,0,1,0,32'hA000_0000); #1 chk("t1_addr0", imemaddr, 32'h0);
    chk("t1_wen", {31'd0, ifid_wen}, 32'd1); chk("t1_next0", next_address_out, 32'h4);
    step(0,0,0,0,1,0,32'hA000_0001); #1 chk("t1_addr1", imemaddr, 32'h4);
    step(0,0,0,0,1,0,32'hA000_0002); #1 chk("t1_addr2", imemaddr, 32'h8);
    chk("t1_next2", next_address_out, 32'hC);
    step(0,0,0,0,1,0,32'hA000_0003);
    // Miss for three cycles at 0x10
    step(0,0,0,0,0,0,32'hB0); #1 chk("t2_miss_addr", imemaddr, 32'h10);
    chk("t2_miss_wen", {31'd0, ifid_wen}, 32'd0);
    step(0,0,0,0,0,0,32'hB1);
    step(0,0,0,0,0,0,32'hB2);
    step(0,0,0,0,1,0,32'hB3); #1 chk("t2_hit_addr", imemaddr, 32'h10);
    chk("t2_hit_wen", {31'd0, ifid_wen}, 32'd1);
    step(0,0,1,32'h20,1,0,32'hB4); #1 chk("t2_after", imemaddr, 32'h14);
    // Redirect during a miss is deferred
    step(0,0,1,32'h100,0,0,32'hC0); #1 chk("t3_flush", {31'd0, ifid_flush}, 32'd1);
    step(0,0,0,0,0,0,32'hC1); #1 chk("t3_hold", imemaddr, 32'h20);
    step(0,0,0,0,1,0,32'hC2); #1 chk("t3_wen", {31'd0, ifid_wen}, 32'd0);
    step(0,0,1,32'h30,0,0,32'hC3); #1 chk("t3_target", imemaddr, 32'h100);
    // Newer redirect overrides the pending one on the completing hit
    step(0,0,1,32'h200,1,0,32'hD0); #1 chk("t4_wen", {31'd0, ifid_wen}, 32'd0);
    step(0,0,1,32'h40,1,0,32'hD1); #1 chk("t4_target", imemaddr, 32'h200);
    // Stall holds PC; redirect beats stall
    step(0,0,0,0,1,1,32'hE0); #1 chk("t5_stall_wen", {31'd0, ifid_wen}, 32'd0);
    step(0,0,0,0,1,1,32'hE1); #1 chk("t5_stall_addr", imemaddr, 32'h40);
    step(0,0,1,32'h80,1,1,32'hE2); #1 chk("t5_flush", {31'd0, ifid_flush}, 32'd1);
    step(0,0,1,32'hFFFF_FFFE,1,0,32'hE3); #1 chk("t5_target", imemaddr, 32'h80);
    // Wrap, halt, reset recovery
    step(0,0,0,0,1,0,32'hF0); #1 chk("t6_top", imemaddr, 32'hFFFF_FFFC);
    chk("t6_wrap_next", next_address_out, 32'h0);
    step(0,1,0,0,1,0,32'hF1); #1 chk("t6_wrapped", imemaddr, 32'h0);
    chk("t6_halt_wen", {31'd0, ifid_wen}, 32'd0);
    step(0,0,0,0,1,0,32'hF2); #1 chk("t6_halted_ren", {31'd0, imemREN}, 32'd0);
    step(0,0,1,32'h500,1,0,32'hF3); #1 chk("t6_halted_flush", {31'd0, ifid_flush}, 32'd0);
    step(1,0,0,0,1,0,32'hF4);
    step(0,0,0,0,1,0,32'hF5); #1 chk("t6_resume_ren", {31'd0, imemREN}, 32'd1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(63) == 0, $urandom_range(47) == 0, $urandom_range(4) == 0,
           $urandom, $urandom_range(2) != 0, $urandom_range(3) == 0, $urandom);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    n_checks++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
